// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and counter arithmetic for the branch pattern table scheduler
package bp_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } bp_state_e;

    localparam logic [1:0] CNT_INIT = 2'b11;
    localparam logic [1:0] CNT_MAX  = 2'b11;
    localparam logic [1:0] CNT_MIN  = 2'b00;

    // Two-bit saturating counter step: never wraps past either end.
    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
        end else begin
            res = (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO of {idx, taken} update records with full/empty flags
module bp_upd_fifo #(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_taken,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             head_taken,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QDEPTH);

    logic [IDX_W:0]   mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign head_idx   = mem_q[rd_ptr_q][IDX_W:1];
    assign head_taken = mem_q[rd_ptr_q][0];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_idx, push_taken};
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bp_table_sched.sv
// rtl/bp_table_sched.sv - single-port counter table arbiter for lookups, queued updates and init sweep
module bp_table_sched
    import bp_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_ready,
    output logic             predict_valid,
    output logic             predict,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_ADDR = '1;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic [1:0]       new_cnt_q, new_cnt_d;
    logic             predict_valid_q, predict_valid_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic             fifo_full;
    logic             fifo_empty;

    assign busy          = (state_q == ST_INIT);
    assign upd_ready     = (state_q != ST_INIT) & ~fifo_full;
    assign fifo_push     = upd_valid & upd_ready;
    assign predict_valid = predict_valid_q;
    assign predict       = predict_valid_q & tbl_rdata[1];

    bp_upd_fifo #(
        .IDX_W  (IDX_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_idx   (upd_idx),
        .push_taken (upd_taken),
        .pop        (fifo_pop),
        .head_idx   (head_idx),
        .head_taken (head_taken),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Port arbitration and next-state logic; a full queue preempts lookups for one read-modify-write.
    always_comb begin
        state_d         = state_q;
        sweep_d         = sweep_q;
        upd_idx_d       = upd_idx_q;
        upd_taken_d     = upd_taken_q;
        new_cnt_d       = new_cnt_q;
        predict_valid_d = 1'b0;
        fifo_pop        = 1'b0;
        lookup_ready    = 1'b0;
        tbl_en          = 1'b0;
        tbl_we          = 1'b0;
        tbl_addr        = '0;
        tbl_wdata       = '0;
        case (state_q)
            ST_INIT: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = sweep_q;
                tbl_wdata = CNT_INIT;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fifo_full) begin
                    fifo_pop    = 1'b1;
                    tbl_en      = 1'b1;
                    tbl_addr    = head_idx;
                    upd_idx_d   = head_idx;
                    upd_taken_d = head_taken;
                    state_d     = ST_UPD_RD;
                end else begin
                    lookup_ready = 1'b1;
                    if (lookup_valid) begin
                        tbl_en          = 1'b1;
                        tbl_addr        = lookup_idx;
                        predict_valid_d = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        tbl_en      = 1'b1;
                        tbl_addr    = head_idx;
                        upd_idx_d   = head_idx;
                        upd_taken_d = head_taken;
                        state_d     = ST_UPD_RD;
                    end
                end
            end
            ST_UPD_RD: begin
                new_cnt_d = cnt_update(tbl_rdata, upd_taken_q);
                state_d   = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = upd_idx_q;
                tbl_wdata = new_cnt_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // While reset is asserted the RAM port stays quiet so a pending write cannot land.
        if (!rst_n) begin
            lookup_ready = 1'b0;
            tbl_en       = 1'b0;
            tbl_we       = 1'b0;
            tbl_addr     = '0;
            tbl_wdata    = '0;
        end
    end

    // State and datapath registers; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_INIT;
            sweep_q         <= '0;
            upd_idx_q       <= '0;
            upd_taken_q     <= 1'b0;
            new_cnt_q       <= '0;
            predict_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sweep_q         <= sweep_d;
            upd_idx_q       <= upd_idx_d;
            upd_taken_q     <= upd_taken_d;
            new_cnt_q       <= new_cnt_d;
            predict_valid_q <= predict_valid_d;
        end
    end

endmodule

// File: tb/tb_bp_table_sched.sv
// tb/tb_bp_table_sched.sv - self-checking bench for bp_table_sched
module tb_bp_table_sched;

    localparam int IDX_W = 10;
    localparam int NENT  = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_ready;
    logic             predict_valid;
    logic             predict;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata = 2'b00;
    logic             busy;

    always #5 clk = ~clk;

    bp_table_sched #(
        .IDX_W  (IDX_W),
        .QDEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_valid  (lookup_valid),
        .lookup_idx    (lookup_idx),
        .lookup_ready  (lookup_ready),
        .predict_valid (predict_valid),
        .predict       (predict),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_ready     (upd_ready),
        .tbl_en        (tbl_en),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata),
        .tbl_rdata     (tbl_rdata),
        .busy          (busy)
    );

    // Counter RAM: one-cycle read latency.
    logic [1:0] ram [NENT];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) ram[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= ram[tbl_addr];
        end
    end

    // Log of update write-backs (outside the init sweep).
    typedef struct packed {
        logic [IDX_W-1:0] addr;
        logic [1:0]       data;
    } wr_t;
    wr_t wr_q[$];
    always @(posedge clk) begin
        if (rst_n && tbl_en && tbl_we && !busy) wr_q.push_back({tbl_addr, tbl_wdata});
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic lv, input logic [IDX_W-1:0] li,
                         input logic uv, input logic [IDX_W-1:0] ui, input logic ut);
        @(negedge clk);
        rst_n        = r;
        lookup_valid = lv;
        lookup_idx   = li;
        upd_valid    = uv;
        upd_idx      = ui;
        upd_taken    = ut;
        #1;
    endtask

    function automatic logic [17:0] obs();
        return {predict_valid, predict, tbl_en, tbl_we, tbl_addr, tbl_wdata, lookup_ready, upd_ready};
    endfunction

    function automatic logic [17:0] ex(input logic pv, input logic pr, input logic en, input logic we,
                                       input logic [IDX_W-1:0] a, input logic [1:0] wd,
                                       input logic lr, input logic ur);
        return {pv, pr, en, we, a, wd, lr, ur};
    endfunction

    typedef struct {
        logic             lv;
        logic [IDX_W-1:0] li;
        logic             uv;
        logic [IDX_W-1:0] ui;
        logic             ut;
        logic [17:0]      exp;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic lv, input logic [IDX_W-1:0] li, input logic uv,
                                input logic [IDX_W-1:0] ui, input logic ut, input logic [17:0] e);
        vec_t v;
        v.lv = lv; v.li = li; v.uv = uv; v.ui = ui; v.ut = ut; v.exp = e;
        return v;
    endfunction

    // Push one update into an empty queue and expect its pop/read, idle rdata cycle, write-back.
    task automatic add_rmw(input logic [IDX_W-1:0] idx, input logic t, input logic [1:0] wd);
        vecs.push_back(mk(0, 0, 1, idx, t, ex(0, 0, 0, 0, 0,   0,  1, 1)));
        vecs.push_back(mk(0, 0, 0, 0,   0, ex(0, 0, 1, 0, idx, 0,  1, 1)));
        vecs.push_back(mk(0, 0, 0, 0,   0, ex(0, 0, 0, 0, 0,   0,  0, 1)));
        vecs.push_back(mk(0, 0, 0, 0,   0, ex(0, 0, 1, 1, idx, wd, 0, 1)));
    endtask

    // Current cycle must be sweep address 0; leaves the bench in the first post-sweep cycle.
    task automatic run_sweep(input string tag);
        int bad = 0;
        int first_bad = -1;
        for (int a = 0; a < NENT; a++) begin
            logic [IDX_W-1:0] ea;
            ea = a[IDX_W-1:0];
            if (!(tbl_en === 1'b1 && tbl_we === 1'b1 && tbl_addr === ea && tbl_wdata === 2'b11 &&
                  busy === 1'b1 && lookup_ready === 1'b0 && upd_ready === 1'b0)) begin
                if (bad == 0) first_bad = a;
                bad++;
            end
            apply(1, 0, 0, 0, 0, 0);
        end
        if (bad != 0) $display("first bad sweep cycle %0d", first_bad);
        chk({tag, " sweep_bad_cycles"}, bad, 0);
        chk({tag, " busy_after_sweep"}, busy, 0);
        chk({tag, " lookup_ready_after_sweep"}, lookup_ready, 1);
        chk({tag, " upd_ready_after_sweep"}, upd_ready, 1);
    endtask

    task automatic drain(input int want);
        for (int i = 0; i < 60 && wr_q.size() < want; i++) apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pushed;
        int lk_acc;
        int pv_cnt;
        int stall;
        int nw;

        rst_n = 0; lookup_valid = 0; lookup_idx = 0; upd_valid = 0; upd_idx = 0; upd_taken = 0;
        repeat (3) apply(0, 0, 0, 0, 0, 0);
        chk("reset_outputs", obs(), 18'd0);
        chk("reset_busy", busy, 1);

        // Init sweep from reset release.
        apply(1, 0, 0, 0, 0, 0);
        run_sweep("init");

        // Directed vector table.
        vecs.push_back(mk(1, 5, 0, 0, 0, ex(0, 0, 1, 0, 5, 0, 1, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 1, 1)));
        add_rmw(5, 0, 2);
        add_rmw(5, 0, 1);
        add_rmw(5, 0, 0);
        vecs.push_back(mk(1, 5, 0, 0, 0, ex(0, 0, 1, 0, 5, 0, 1, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 1, 1)));
        add_rmw(5, 0, 0);
        add_rmw(5, 1, 1);
        add_rmw(5, 1, 2);
        add_rmw(5, 1, 3);
        add_rmw(5, 1, 3);
        vecs.push_back(mk(1, 5,    0, 0, 0, ex(0, 0, 1, 0, 5,    0, 1, 1)));
        vecs.push_back(mk(1, 1023, 0, 0, 0, ex(1, 1, 1, 0, 1023, 0, 1, 1)));
        vecs.push_back(mk(1, 0,    0, 0, 0, ex(1, 1, 1, 0, 0,    0, 1, 1)));
        vecs.push_back(mk(0, 0,    0, 0, 0, ex(1, 1, 0, 0, 0,    0, 1, 1)));
        vecs.push_back(mk(0, 0,    0, 0, 0, ex(0, 0, 0, 0, 0,    0, 1, 1)));
        foreach (vecs[i]) begin
            apply(1, vecs[i].lv, vecs[i].li, vecs[i].uv, vecs[i].ui, vecs[i].ut);
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Continuous lookups while pushing five not-taken updates to 10..14.
        wr_q.delete();
        pushed = 0; lk_acc = 0; pv_cnt = 0; stall = 0;
        for (int c = 0; c < 12; c++) begin
            logic uv;
            uv = (pushed < 5);
            apply(1, 1, IDX_W'(100 + c), uv, IDX_W'(10 + pushed), 0);
            if (c == 3) begin
                chk("A c3 upd_ready", upd_ready, 1);
                chk("A c3 lookup_ready", lookup_ready, 1);
            end
            if (c == 4) begin
                chk("A c4 upd_ready_full", upd_ready, 0);
                chk("A c4 lookup_stall", lookup_ready, 0);
                chk("A c4 pushes_before_full", pushed, 4);
                chk("A c4 pop_read_addr", tbl_addr, 10);
            end
            if (c >= 4 && c <= 6 && !lookup_ready) stall++;
            if (uv && upd_ready) pushed++;
            if (lookup_ready) lk_acc++;
            if (predict_valid) pv_cnt++;
        end
        chk("A stall_cycles", stall, 3);
        chk("A all_pushed", pushed, 5);
        for (int i = 0; i < 60 && wr_q.size() < 5; i++) begin
            apply(1, 0, 0, 0, 0, 0);
            if (predict_valid) pv_cnt++;
        end
        apply(1, 0, 0, 0, 0, 0);
        if (predict_valid) pv_cnt++;
        chk("A predictions_equal_lookups", pv_cnt, lk_acc);
        chk("A write_count", wr_q.size(), 5);
        nw = (wr_q.size() < 5) ? wr_q.size() : 5;
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("A wr%0d addr", i), wr_q[i].addr, 10 + i);
            chk($sformatf("A wr%0d data", i), wr_q[i].data, 2);
        end

        // Push and pop together with three entries queued; order must hold.
        wr_q.delete();
        apply(1, 1, 7, 1, 20, 0);
        chk("B c0 upd_ready", upd_ready, 1);
        apply(1, 1, 7, 1, 21, 1);
        apply(1, 1, 7, 1, 22, 0);
        apply(1, 0, 0, 1, 23, 1);
        chk("B c3 pop_with_push", obs(), ex(1, 1, 1, 0, 20, 0, 1, 1));
        apply(1, 0, 0, 1, 24, 0);
        chk("B c4 occupancy_three", upd_ready, 1);
        apply(1, 0, 0, 0, 0, 0);
        chk("B c5 now_full", upd_ready, 0);
        drain(5);
        chk("B write_count", wr_q.size(), 5);
        nw = (wr_q.size() < 5) ? wr_q.size() : 5;
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("B wr%0d addr", i), wr_q[i].addr, 20 + i);
            chk($sformatf("B wr%0d data", i), wr_q[i].data, (i % 2 == 0) ? 2 : 3);
        end

        // Reset asserted during UPD_RD.
        wr_q.delete();
        apply(1, 0, 0, 1, 30, 0);
        apply(1, 0, 0, 1, 31, 0);
        chk("C pop_read_addr", tbl_addr, 30);
        apply(0, 0, 0, 1, 32, 0);
        chk("C rd_cycle_no_port", tbl_en, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("C reset_outputs", obs(), 18'd0);
        chk("C reset_busy", busy, 1);
        apply(1, 0, 0, 0, 0, 0);
        run_sweep("rst");
        repeat (8) apply(1, 0, 0, 0, 0, 0);
        chk("C no_writes_after_reset", wr_q.size(), 0);
        chk("C ram30_initial", ram[30], 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
